// File: rtl/adder_pkg.sv
// ---------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the multi-word adder: the FSM state encoding and the
// default limb width / limb count used when the top is instantiated without
// overrides.
// ---------------------------------------------------------------------------
package adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int DEF_N     = 32;
  localparam int DEF_WORDS = 4;

endpackage

// File: rtl/limb_adder.sv
// ---------------------------------------------------------------------------
// limb_adder
// Combinational N-bit add-with-carry for one limb. The sum is formed N+1 bits
// wide so the carry out of the top bit is never lost.
// Ports:
//   a, b  : N-bit limb operands
//   cin   : carry in
//   sum   : N-bit limb result
//   cout  : carry out (bit N of the full sum)
// ---------------------------------------------------------------------------
module limb_adder #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] w_full;

  assign w_full = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
  assign sum    = w_full[N-1:0];
  assign cout   = w_full[N];

endmodule

// File: rtl/multi_word_adder.sv
// ---------------------------------------------------------------------------
// multi_word_adder
// Sequential N*WORDS-bit adder/subtractor that processes one N-bit limb per
// clock, least significant limb first. Subtraction is a + ~b + 1, with the +1
// supplied as the initial carry, so carry_out=1 means "no borrow".
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : request, accepted only when idle
//   sub        : 0 = a+b, 1 = a-b (latched with start)
//   a, b       : operands (latched with start)
//   busy       : high while the operation is running or finishing
//   done       : one-cycle pulse when result/carry_out are valid
//   result     : sum/difference modulo 2^(N*WORDS)
//   carry_out  : final carry
//   overflow   : signed overflow of the full-width operation
//                (present only when OVERFLOW_FLAG_EN is defined)
// ---------------------------------------------------------------------------
module multi_word_adder
  import adder_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int WORDS = DEF_WORDS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [N*WORDS-1:0] a,
  input  logic [N*WORDS-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [N*WORDS-1:0] result,
`ifdef OVERFLOW_FLAG_EN
  output logic             overflow,
`endif
  output logic             carry_out
);

  localparam int W     = N * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_t             r_state;
  state_t             w_next;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic [W-1:0]       r_result;
  logic               r_sub;
  logic               r_carry;
  logic               r_carry_out;
  logic               r_done;
  logic [IDX_W-1:0]   r_idx;

  logic               w_last;
  logic [N-1:0]       w_a_limb;
  logic [N-1:0]       w_b_limb;
  logic [N-1:0]       w_sum;
  logic               w_cout;

  assign w_last   = (r_idx == IDX_W'(WORDS - 1));
  assign w_a_limb = r_a[r_idx*N +: N];
  assign w_b_limb = r_sub ? ~r_b[r_idx*N +: N] : r_b[r_idx*N +: N];

  limb_adder #(.N(N)) u_limb (
    .a    (w_a_limb),
    .b    (w_b_limb),
    .cin  (r_carry),
    .sum  (w_sum),
    .cout (w_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start)  w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // done is registered from the DONE state so it lands one cycle after the
  // final limb, giving a fixed WORDS+1 cycle start-to-done latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_sub       <= 1'b0;
      r_carry     <= 1'b0;
      r_idx       <= '0;
      r_result    <= '0;
      r_carry_out <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= (r_state == S_DONE);
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_sub   <= sub;
            r_idx   <= '0;
            r_carry <= sub;
          end
        end
        S_RUN: begin
          r_result[r_idx*N +: N] <= w_sum;
          r_carry                <= w_cout;
          r_carry_out            <= w_cout;
          if (!w_last) r_idx <= r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef OVERFLOW_FLAG_EN
  logic r_overflow;

  // Signed overflow: both effective operands share a sign that the result
  // does not. Only the top limb carries the sign bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (r_state == S_RUN && w_last) begin
      r_overflow <= (w_a_limb[N-1] == w_b_limb[N-1]) &&
                    (w_sum[N-1] != w_a_limb[N-1]);
    end
  end

  assign overflow = r_overflow;
`endif

  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign result    = r_result;
  assign carry_out = r_carry_out;

endmodule

// File: tb/tb_multi_word_adder.sv
module tb_multi_word_adder;

  logic         clk = 1'b0;
  logic         rst;
  logic         start0, sub0;
  logic [127:0] a0, b0;
  logic         busy0, done0, cout0;
  logic [127:0] res0;
  logic         start1, sub1;
  logic [7:0]   a1, b1;
  logic         busy1, done1, cout1;
  logic [7:0]   res1;
`ifdef OVERFLOW_FLAG_EN
  logic         ovf0, ovf1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_word_adder #(.N(32), .WORDS(4)) dut0 (
    .clk       (clk),
    .rst       (rst),
    .start     (start0),
    .sub       (sub0),
    .a         (a0),
    .b         (b0),
    .busy      (busy0),
    .done      (done0),
    .result    (res0),
`ifdef OVERFLOW_FLAG_EN
    .overflow  (ovf0),
`endif
    .carry_out (cout0)
  );

  multi_word_adder #(.N(8), .WORDS(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .start     (start1),
    .sub       (sub1),
    .a         (a1),
    .b         (b1),
    .busy      (busy1),
    .done      (done1),
    .result    (res1),
`ifdef OVERFLOW_FLAG_EN
    .overflow  (ovf1),
`endif
    .carry_out (cout1)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pulse start on one DUT and count rising edges until done is seen.
  // lat = 99 means done never arrived within the budget.
  task automatic run_op(input bit sel, input logic [127:0] a, input logic [127:0] b,
                        input logic s, output int lat);
    if (sel == 1'b0) begin a0 = a; b0 = b; sub0 = s; start0 = 1'b1; end
    else begin a1 = a[7:0]; b1 = b[7:0]; sub1 = s; start1 = 1'b1; end
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
    lat = 99;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      @(negedge clk);
      if ((sel == 1'b0 && done0) || (sel == 1'b1 && done1)) begin
        lat = c;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int ndone;
    rst = 1'b1; start0 = 0; sub0 = 0; a0 = '0; b0 = '0;
    start1 = 0; sub1 = 0; a1 = '0; b1 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    chk("reset_busy",   128'(busy0), 128'(0));
    chk("reset_done",   128'(done0), 128'(0));
    chk("reset_result", res0, 128'(0));
    chk("reset_cout",   128'(cout0), 128'(0));
`ifdef OVERFLOW_FLAG_EN
    chk("reset_ovf",    128'(ovf0), 128'(0));
`endif

    // all-ones + 1 wraps to zero with a carry out
    run_op(0, {128{1'b1}}, 128'd1, 1'b0, lat);
    chk("wrap_latency", 128'(lat), 128'd5);
    chk("wrap_result",  res0, 128'd0);
    chk("wrap_cout",    128'(cout0), 128'd1);
    @(negedge clk);
    chk("done_one_cycle", 128'(done0), 128'd0);
    chk("idle_busy",      128'(busy0), 128'd0);

    // subtraction with and without borrow
    run_op(0, 128'h5, 128'h7, 1'b1, lat);
    chk("sub_borrow_result", res0, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE);
    chk("sub_borrow_cout",   128'(cout0), 128'd0);
    run_op(0, 128'h7, 128'h5, 1'b1, lat);
    chk("sub_result", res0, 128'd2);
    chk("sub_cout",   128'(cout0), 128'd1);

    // carries crossing limb boundaries
    run_op(0, 128'h00000001_FFFFFFFF_00000000_80000000,
              128'h00000000_00000001_00000000_80000000, 1'b0, lat);
    chk("ripple_result", res0, 128'h00000002_00000000_00000001_00000000);
    chk("ripple_cout",   128'(cout0), 128'd0);

    // start while busy is ignored; operand changes while busy have no effect
    a0 = 128'd10; b0 = 128'd20; sub0 = 1'b0; start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    @(posedge clk); #1;
    chk("busy_in_run", 128'(busy0), 128'd1);
    start0 = 1'b1; a0 = 128'd1000; b0 = 128'd1; sub0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done0) ndone++;
    end
    chk("ignore_start_result", res0, 128'd30);
    chk("ignore_start_ndone",  128'(ndone), 128'd1);
    chk("ignore_start_busy",   128'(busy0), 128'd0);
    a0 = 128'd77;
    repeat (2) @(negedge clk);
    chk("result_hold", res0, 128'd30);

    // reset during the third RUN cycle aborts without a done pulse
    a0 = {128{1'b1}}; b0 = {128{1'b1}}; sub0 = 1'b0; start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    @(posedge clk); @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("pre_abort_busy", 128'(busy0), 128'd1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy",   128'(busy0), 128'd0);
    chk("abort_result", res0, 128'd0);
    chk("abort_cout",   128'(cout0), 128'd0);
    ndone = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done0) ndone++;
    end
    chk("abort_no_done", 128'(ndone), 128'd0);
    run_op(0, 128'd3, 128'd4, 1'b0, lat);
    chk("after_abort_latency", 128'(lat), 128'd5);
    chk("after_abort_result",  res0, 128'd7);

    // reset wins over start in the same cycle
    @(posedge clk); #1 rst = 1'b1; start0 = 1'b1;
    @(posedge clk); #1 rst = 1'b0; start0 = 1'b0;
    @(negedge clk);
    chk("rst_over_start_busy", 128'(busy0), 128'd0);
    @(negedge clk);
    chk("rst_over_start_idle", 128'(busy0), 128'd0);

    // single-limb instance
    run_op(1, 128'hFF, 128'h01, 1'b0, lat);
    chk("w1_latency", 128'(lat), 128'd2);
    chk("w1_result",  128'(res1), 128'h00);
    chk("w1_cout",    128'(cout1), 128'd1);

`ifdef OVERFLOW_FLAG_EN
    run_op(0, 128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'd1, 1'b0, lat);
    chk("ovf_set", 128'(ovf0), 128'd1);
    run_op(0, 128'd1, 128'd1, 1'b0, lat);
    chk("ovf_clear", 128'(ovf0), 128'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
